// File: rtl/execute_md_unit.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier /
// restoring divider that owns the architectural HI/LO pair.
module execute_md_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic              FlushIn,
    input  logic [3:0]        OpIn,
    input  logic [DATA_W-1:0] AIn,
    input  logic [DATA_W-1:0] BIn,
    input  logic [REG_W-1:0]  DestRegIn,
    input  logic              RegWriteIn,
    input  logic [DATA_W-1:0] PCValueIn,
    input  logic [DATA_W-1:0] SignExtendOffsetIn,
    output logic              OutValid,
    output logic [DATA_W-1:0] ResultOut,
    output logic [REG_W-1:0]  DestRegOut,
    output logic              RegWriteOut,
    output logic [DATA_W-1:0] BranchTargetOut,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_MOVZ = 4'd6,  OP_MOVN = 4'd7;
    localparam logic [3:0] OP_MULT = 4'd8,  OP_DIV  = 4'd10, OP_DIVU = 4'd11;
    localparam logic [3:0] OP_MADD = 4'd12, OP_MSUB = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

    typedef enum logic {IDLE, ITER} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   mag_a, mag_b, a_raw;
    logic                neg_q, neg_r, b_zero;
    logic [2*DATA_W-1:0] acc;
    logic [REG_W-1:0]    dest_q;

    logic                accept, is_iter, is_div, signed_in, a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a_in, mag_b_in, alu_res;
    logic                alu_rw;

    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_s, fin;
    logic [DATA_W-1:0]   quo, rem;

    assign InReady   = (state == IDLE);
    assign accept    = InValid & InReady & ~FlushIn;
    assign is_iter   = (OpIn >= OP_MULT) && (OpIn <= OP_MSUB);
    assign is_div    = (OpIn == OP_DIV) || (OpIn == OP_DIVU);
    assign signed_in = (OpIn == OP_MULT) || (OpIn == OP_DIV) || (OpIn == OP_MADD) || (OpIn == OP_MSUB);
    assign a_neg     = signed_in & AIn[DATA_W-1];
    assign b_neg     = signed_in & BIn[DATA_W-1];
    assign mag_a_in  = a_neg ? -AIn : AIn;
    assign mag_b_in  = b_neg ? -BIn : BIn;

    always_comb begin
        alu_res = '0;
        alu_rw  = RegWriteIn;
        case (OpIn)
            OP_ADD:  alu_res = AIn + BIn;
            OP_SUB:  alu_res = AIn - BIn;
            OP_AND:  alu_res = AIn & BIn;
            OP_OR:   alu_res = AIn | BIn;
            OP_XOR:  alu_res = AIn ^ BIn;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(AIn) < $signed(BIn))};
            OP_MOVZ: begin alu_res = AIn; alu_rw = (BIn == '0); end
            OP_MOVN: begin alu_res = AIn; alu_rw = (BIn != '0); end
            OP_MFHI: alu_res = HiOut;
            OP_MFLO: alu_res = LoOut;
            default: ;
        endcase
    end

    // One iteration of each engine; the final step is folded into the
    // sign-fix / accumulate so HI/LO land on the edge the count hits zero.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next  = {mul_sum, acc[DATA_W-1:1]};
        div_shift = acc[2*DATA_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_next  = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]), acc[DATA_W-2:0], div_ge};
        prod_s    = neg_q ? -mul_next : mul_next;
        quo       = div_next[DATA_W-1:0];
        rem       = div_next[2*DATA_W-1:DATA_W];
        fin       = prod_s;
        case (op_q)
            OP_MADD: fin = {HiOut, LoOut} + prod_s;
            OP_MSUB: fin = {HiOut, LoOut} - prod_s;
            OP_DIV, OP_DIVU: begin
                if (b_zero) fin = {a_raw, {DATA_W{1'b1}}};
                else        fin = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            count           <= '0;
            op_q            <= '0;
            mag_a           <= '0;
            mag_b           <= '0;
            a_raw           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            b_zero          <= 1'b0;
            acc             <= '0;
            dest_q          <= '0;
            OutValid        <= 1'b0;
            ResultOut       <= '0;
            DestRegOut      <= '0;
            RegWriteOut     <= 1'b0;
            BranchTargetOut <= '0;
            HiOut           <= '0;
            LoOut           <= '0;
        end else begin
            OutValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        BranchTargetOut <= PCValueIn + (SignExtendOffsetIn << 2);
                        if (is_iter) begin
                            state  <= ITER;
                            count  <= CNT_W'(DATA_W);
                            op_q   <= OpIn;
                            mag_a  <= mag_a_in;
                            mag_b  <= mag_b_in;
                            a_raw  <= AIn;
                            b_zero <= (BIn == '0);
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dest_q <= DestRegIn;
                            acc    <= is_div ? {{DATA_W{1'b0}}, mag_a_in} : {{DATA_W{1'b0}}, mag_b_in};
                        end else begin
                            OutValid    <= 1'b1;
                            ResultOut   <= alu_res;
                            DestRegOut  <= DestRegIn;
                            RegWriteOut <= alu_rw;
                        end
                    end
                end
                ITER: begin
                    if (FlushIn) begin
                        state <= IDLE;
                    end else begin
                        acc   <= (op_q == OP_DIV || op_q == OP_DIVU) ? div_next : mul_next;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state          <= IDLE;
                            {HiOut, LoOut} <= fin;
                            OutValid       <= 1'b1;
                            ResultOut      <= '0;
                            RegWriteOut    <= 1'b0;
                            DestRegOut     <= dest_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_md_unit.sv
// Bench for execute_md_unit: directed literal cases, then random traffic
// checked every cycle against a transaction-level arithmetic model.
module tb_execute_md_unit;

    localparam int W = 32;

    logic        Clk = 1'b0;
    logic        Reset, InValid, FlushIn, RegWriteIn;
    logic [3:0]  OpIn;
    logic [31:0] AIn, BIn, PCValueIn, SignExtendOffsetIn;
    logic [4:0]  DestRegIn;
    logic        InReady, OutValid, RegWriteOut;
    logic [31:0] ResultOut, BranchTargetOut, HiOut, LoOut;
    logic [4:0]  DestRegOut;

    logic        v16, rdy16, ov16, rw16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16, bt16, hi16, lo16;
    logic [4:0]  dst16;

    always #5 Clk = ~Clk;

    execute_md_unit #(.DATA_W(32), .REG_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .FlushIn(FlushIn),
        .OpIn(OpIn), .AIn(AIn), .BIn(BIn), .DestRegIn(DestRegIn), .RegWriteIn(RegWriteIn),
        .PCValueIn(PCValueIn), .SignExtendOffsetIn(SignExtendOffsetIn), .OutValid(OutValid),
        .ResultOut(ResultOut), .DestRegOut(DestRegOut), .RegWriteOut(RegWriteOut),
        .BranchTargetOut(BranchTargetOut), .HiOut(HiOut), .LoOut(LoOut)
    );

    execute_md_unit #(.DATA_W(16), .REG_W(5)) dut16 (
        .Clk(Clk), .Reset(Reset), .InValid(v16), .InReady(rdy16), .FlushIn(1'b0),
        .OpIn(op16), .AIn(a16), .BIn(b16), .DestRegIn(5'd1), .RegWriteIn(1'b1),
        .PCValueIn(16'h0), .SignExtendOffsetIn(16'h0), .OutValid(ov16),
        .ResultOut(res16), .DestRegOut(dst16), .RegWriteOut(rw16),
        .BranchTargetOut(bt16), .HiOut(hi16), .LoOut(lo16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_busy;
    logic [31:0] m_hi, m_lo, m_res, m_bt, p_hi, p_lo;
    logic [4:0]  m_dst, p_dst;
    logic        m_ov, m_rw, m_single;
    bit          cmp_on = 0;

    function automatic logic [63:0] iter_result(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'h0;
        case (op)
            4'd8:  res = sa * sb;
            4'd9:  res = {32'h0, a} * {32'h0, b};
            4'd12: res = {hi, lo} + 64'(sa * sb);
            4'd13: res = {hi, lo} - 64'(sa * sb);
            4'd10: begin
                if (b == 0)                                     res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd11: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6, 4'd7: return a;
            4'd14: return hi;
            4'd15: return lo;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_busy = 0; m_hi = 0; m_lo = 0; m_ov = 0; m_res = 0;
            m_dst = 0; m_rw = 0; m_bt = 0; m_single = 0;
        end else begin
            m_ov = 0;
            m_single = 0;
            if (m_busy > 0) begin
                if (FlushIn) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_hi = p_hi; m_lo = p_lo;
                        m_ov = 1; m_res = 0; m_rw = 0; m_dst = p_dst;
                    end
                end
            end else if (InValid && !FlushIn) begin
                m_bt = PCValueIn + (SignExtendOffsetIn << 2);
                if (OpIn >= 8 && OpIn <= 13) begin
                    {p_hi, p_lo} = iter_result(OpIn, AIn, BIn, m_hi, m_lo);
                    p_dst  = DestRegIn;
                    m_busy = W;
                end else begin
                    m_ov = 1; m_single = 1;
                    m_res = alu(OpIn, AIn, BIn, m_hi, m_lo);
                    m_dst = DestRegIn;
                    m_rw  = (OpIn == 4'd6) ? (BIn == 0) : (OpIn == 4'd7) ? (BIn != 0) : RegWriteIn;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_on) begin
            chk("in_ready", InReady, m_busy == 0);
            chk("out_valid", OutValid, m_ov);
            chk("hi", HiOut, m_hi);
            chk("lo", LoOut, m_lo);
            if (m_ov) begin
                chk("result", ResultOut, m_res);
                chk("dest", DestRegOut, m_dst);
                chk("regwrite", RegWriteOut, m_rw);
                if (m_single) chk("branch_target", BranchTargetOut, m_bt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] d, input logic rw);
        @(negedge Clk);
        InValid = 1; OpIn = op; AIn = a; BIn = b; DestRegIn = d; RegWriteIn = rw;
        PCValueIn = $urandom; SignExtendOffsetIn = $urandom;
        @(negedge Clk);
        InValid = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!OutValid && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("done_seen", OutValid, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, cnt;
        Reset = 1; InValid = 0; FlushIn = 0; RegWriteIn = 0; OpIn = 0;
        AIn = 0; BIn = 0; DestRegIn = 0; PCValueIn = 0; SignExtendOffsetIn = 0;
        v16 = 0; op16 = 0; a16 = 0; b16 = 0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 0;
        cmp_on = 1;
        chk("reset_ready", InReady, 1);
        chk("reset_hi", HiOut, 0);
        chk("reset_ov", OutValid, 0);

        send(4'd0, 32'hFFFFFFFF, 32'h1, 5'd3, 1'b1);
        chk("add_res", ResultOut, 0);
        chk("add_ov", OutValid, 1);
        chk("add_rw", RegWriteOut, 1);
        chk("add_dst", DestRegOut, 3);
        send(4'd5, 32'hFFFFFFFF, 32'h1, 5'd4, 1'b1);
        chk("slt_res", ResultOut, 1);
        send(4'd6, 32'h55, 32'h0, 5'd5, 1'b0);
        chk("movz_rw", RegWriteOut, 1);
        send(4'd7, 32'h55, 32'h0, 5'd6, 1'b1);
        chk("movn_rw", RegWriteOut, 0);
        chk("movn_res", ResultOut, 32'h55);

        send(4'd8, 32'hFFFFFFFD, 32'd7, 5'd7, 1'b1);
        wait_done(n);
        chk("mult_latency", n, 32);
        chk("mult_hi", HiOut, 32'hFFFFFFFF);
        chk("mult_lo", LoOut, 32'hFFFFFFEB);
        chk("mult_rw", RegWriteOut, 0);
        chk("mult_dst", DestRegOut, 7);
        @(negedge Clk);
        chk("mult_pulse", OutValid, 0);
        send(4'd15, 32'h0, 32'h0, 5'd8, 1'b1);
        chk("mflo_res", ResultOut, 32'hFFFFFFEB);

        send(4'd10, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b1);
        wait_done(n);
        chk("div_lo", LoOut, 32'hFFFFFFFD);
        chk("div_hi", HiOut, 32'hFFFFFFFF);
        send(4'd11, 32'd7, 32'd0, 5'd9, 1'b1);
        wait_done(n);
        chk("divu0_lo", LoOut, 32'hFFFFFFFF);
        chk("divu0_hi", HiOut, 32'd7);

        send(4'd9, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1);
        wait_done(n);
        send(4'd12, 32'd1, 32'd1, 5'd2, 1'b1);
        wait_done(n);
        chk("madd_hi", HiOut, 32'd1);
        chk("madd_lo", LoOut, 32'd0);

        // Flush on the tenth edge of a MULT
        send(4'd8, 32'd5, 32'd5, 5'd2, 1'b1);
        repeat (8) @(negedge Clk);
        @(negedge Clk);
        FlushIn = 1;
        @(negedge Clk);
        FlushIn = 0;
        chk("flush_ready", InReady, 1);
        chk("flush_ov", OutValid, 0);
        chk("flush_hi", HiOut, 32'd1);
        chk("flush_lo", LoOut, 32'd0);
        cnt = 0;
        repeat (40) begin @(negedge Clk); if (OutValid) cnt++; end
        chk("flush_no_ov", cnt, 0);

        // Reset in the middle of a DIVU
        send(4'd11, 32'd100, 32'd3, 5'd11, 1'b1);
        repeat (4) @(negedge Clk);
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        chk("rst_hi", HiOut, 0);
        chk("rst_lo", LoOut, 0);
        chk("rst_ov", OutValid, 0);
        chk("rst_res", ResultOut, 0);
        chk("rst_dst", DestRegOut, 0);
        chk("rst_rw", RegWriteOut, 0);
        chk("rst_bt", BranchTargetOut, 0);
        chk("rst_ready", InReady, 1);
        cnt = 0;
        repeat (40) begin @(negedge Clk); if (OutValid) cnt++; end
        chk("rst_no_ov", cnt, 0);

        // Narrow build
        @(negedge Clk);
        v16 = 1; op16 = 4'd9; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge Clk);
        v16 = 0;
        n = 0;
        while (!ov16 && n < 100) begin @(negedge Clk); n++; end
        chk("w16_latency", n, 16);
        chk("w16_hi", hi16, 16'hFFFE);
        chk("w16_lo", lo16, 16'h0001);

        repeat (4000) begin
            @(negedge Clk);
            InValid    = ($urandom_range(0, 3) != 0);
            FlushIn    = ($urandom_range(0, 149) == 0);
            Reset      = ($urandom_range(0, 999) == 0);
            OpIn       = 4'($urandom_range(0, 15));
            AIn        = pick();
            BIn        = pick();
            DestRegIn  = 5'($urandom);
            RegWriteIn = 1'($urandom);
            PCValueIn  = $urandom;
            SignExtendOffsetIn = $urandom;
        end
        @(negedge Clk);
        InValid = 0; FlushIn = 0; Reset = 0;
        repeat (40) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_md_unit.md
# execute_md_unit

Parametrised execute stage with an iterative multiply/divide engine and an architectural HI/LO register pair. It accepts one operation per valid/ready handshake, completes simple ALU ops in one cycle, and runs MULT/DIV/MADD/MSUB over DATA_W cycles while back-pressuring the ID/EX register. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- DATA_W, 32, operand/result/HI/LO width (even, ≥8)
- REG_W, 5, destination register field width
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- InValid  in  1  operation presented
- InReady  out  1  unit can accept; high only in IDLE
- FlushIn  in  1  abort in-flight iterative op, drop presented op
- OpIn  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MOVZ, 7 MOVN, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MADD, 13 MSUB, 14 MFHI, 15 MFLO
- AIn, BIn  in  DATA_W  operands (rs, rt-or-immediate)
- DestRegIn  in  REG_W  destination register
- RegWriteIn  in  1  decode-time write enable
- PCValueIn, SignExtendOffsetIn  in  DATA_W  branch target inputs
- OutValid  out  1  one-cycle completion pulse
- ResultOut  out  DATA_W  registered result
- DestRegOut  out  REG_W  registered destination
- RegWriteOut  out  1  registered, qualified write enable
- BranchTargetOut  out  DATA_W  registered PCValueIn + (SignExtendOffsetIn << 2)
- HiOut, LoOut  out  DATA_W  architectural HI/LO

## Operation
- Accept = InValid & InReady & ~FlushIn at a rising edge. Inputs are otherwise ignored.
- States: IDLE, ITER, DONE-free design. The unit returns from ITER to IDLE on the edge on which the count reaches zero.
- Single-cycle ops (0–7, 14, 15): results are registered at the accept edge and OutValid is high for one cycle; the FSM stays in IDLE.
  - ADD/SUB wrap modulo 2^DATA_W with no overflow trap.
  - SLT is signed and returns 1 or 0.
  - MFHI/MFLO return the current HiOut/LoOut.
  - MOVZ: ResultOut=AIn, RegWriteOut=(BIn==0). MOVN: ResultOut=AIn, RegWriteOut=(BIn!=0).
  - For all other single-cycle ops, RegWriteOut=RegWriteIn.
- Iterative ops (8–13): the accept edge latches operand magnitudes, op, and counter=DATA_W, then enters ITER.
  - MULT/MULTU use shift-add, one bit per cycle. Product is 2·DATA_W bits: HI = upper half, LO = lower half.
  - MADD/MSUB form the signed product, then {HI,LO} ± product, modulo 2^(2·DATA_W).
  - DIV/DIVU use restoring division, one bit per cycle. LO = quotient, HI = remainder.
  - Signed forms: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Divide by zero (B==0), signed or unsigned: LO = all ones, HI = AIn. Full latency still applies.
  - Signed MIN / −1: LO = MIN, HI = 0.
  - Completion writes HI/LO and pulses OutValid with RegWriteOut=0, ResultOut=0, DestRegOut=latched value.
- FlushIn in ITER: the unit returns to IDLE at that edge. HI/LO are unchanged and there is no OutValid.
- FlushIn in IDLE: the presented op is dropped with no OutValid, even if InValid is high.
- Reset: ITER is aborted. OutValid, ResultOut, DestRegOut, RegWriteOut, BranchTargetOut, HiOut and LoOut all go to 0, and the FSM goes to IDLE. Reset has priority over FlushIn and accept.

## Timing
- Single-cycle op accepted at edge E0: outputs valid in cycle E0→E1, and OutValid falls at E1 unless a new op is accepted.
- Iterative op accepted at E0:
  - InReady is low from E0 and returns high at E_DATA_W (edge E0+DATA_W).
  - HI/LO update and OutValid rise at E_DATA_W, i.e. latency = DATA_W cycles.
- Back-to-back: a new op may be accepted at E_DATA_W+1 at the earliest. MFHI accepted then returns the new HI.
- No combinational path from InValid to InReady. InReady depends only on FSM state.
- Reset asserted for one cycle suffices. InReady is high in the first cycle after Reset deasserts.

## Test plan
- Reset, then ADD A=0xFFFFFFFF, B=1 → next cycle OutValid=1, ResultOut=0, RegWriteOut=RegWriteIn; SLT A=0xFFFFFFFF, B=1 → 1.
- MOVZ A=0x55, B=0 → RegWriteOut=1; MOVN A=0x55, B=0 → RegWriteOut=0, ResultOut=0x55.
- MULT A=−3, B=7 (DATA_W=32) → InReady low 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, OutValid one pulse; MFLO → 0xFFFFFFEB.
- DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7.
- MADD with HI/LO={0,0xFFFFFFFF}, A=1, B=1 → HI=1, LO=0; FlushIn at cycle 10 of a MULT → HI/LO unchanged, no OutValid, InReady high next cycle.
- Reset at cycle 5 of a DIVU → all outputs 0, no OutValid; DATA_W=16 build: MULTU 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001 after 16 cycles.
